fifo_sync_param: RTL
====================

# fifo_sync_param

Single-clock, parametrised FIFO for buffering within one clock domain. Generalises the existing 8-bit, 16-entry dual-clock FIFO to any data width and power-of-two depth, and adds:
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow flags;
- a synchronous flush.

## Interface
- DATA_W, 8: data width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- FWFT, 0: 0 = standard read mode, 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request (pop in FWFT mode).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data qualifier.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when a write is rejected.
- underflow  out  1  sticky; set when a read is rejected.

## Operation
- Pointers: wr_ptr and rd_ptr, each ADDR_W+1 bits, binary.
  - Memory index = ptr[ADDR_W-1:0]; the MSB distinguishes full from empty on wrap.
  - count = wr_ptr - rd_ptr, computed modulo 2**(ADDR_W+1).
- Write acceptance: wr_acc = wr_en & ~full.
  - No write-through when full, even if a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_en & ~empty.
  - No read-through when empty, even if a write is accepted in the same cycle.
- Rejected requests:
  - wr_en & full sets overflow; the data is dropped.
  - rd_en & empty sets underflow.
  - Both flags hold until rst or clear.
- Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged. Legal at any fill level in 1..DEPTH-1.
- Pointer wrap: wr_ptr and rd_ptr wrap naturally at 2**(ADDR_W+1); no special handling.
- Standard mode (FWFT=0):
  - rd_data is registered, loaded with mem[rd_ptr] on rd_acc.
  - rd_valid is a one-cycle pulse in the cycle after rd_acc.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] and rd_valid = ~empty, both combinational from registered state.
  - rd_en acknowledges (pops) the presented word.
  - rd_data is forced to 0 while empty.
- clear (synchronous):
  - Pointers go to 0; overflow and underflow are cleared.
  - clear overrides wr_en and rd_en in the same cycle; no write or read is performed.
  - In standard mode, rd_valid is forced to 0 in the cycle after clear.
- rst (asynchronous): same effect as clear, plus rd_data <= 0.
  - Memory contents are not reset.
  - A reset mid-operation discards all data immediately.
- Reset values:
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - count = 0, rd_valid = 0, rd_data = 0.
  - overflow = 0, underflow = 0.
- Elaboration must fail (generate-time check) if AFULL_TH or AEMPTY_TH is outside its legal range.

## Timing
- Write latency: a word written at edge N is readable from edge N onward.
  - FWFT: rd_valid = 1 and rd_data valid in cycle N+1 (after edge N).
  - Standard: rd_en sampled at edge N+1 at the earliest; rd_valid and data in cycle N+2.
- Status outputs (full, empty, almost_*, count) are combinational from the registered pointers only. They reflect an operation in the cycle after its committing edge.
- Status outputs never depend combinationally on wr_en or rd_en.
- overflow and underflow assert in the cycle after the offending request.
- Full throughput: one write and one read per cycle, sustained.

## Structure
- Package fifo_pkg holds:
  - default DATA_W and ADDR_W;
  - localparams FWFT_OFF = 0 and FWFT_ON = 1;
  - a function computing DEPTH from ADDR_W.
- Sub-module fifo_regfile:
  - DEPTH x DATA_W array;
  - synchronous write port (we = wr_acc);
  - asynchronous read port.
- Top level: pointers, flag logic, read-mode output stage.

## Test plan
- Fill and drain (DATA_W=8, ADDR_W=4, standard mode):
  - Write 0x00..0x0F on 16 consecutive cycles: full=1, count=16, almost_full set at count 14.
  - Read 16 times: data 0x00..0x0F in order, each one cycle after its rd_en; empty=1 after the last read.
- Overflow and underflow:
  - Write 0xAA when full: overflow=1, count stays 16, 0xAA never appears on rd_data.
  - rd_en when empty: underflow=1, rd_valid stays 0.
  - clear drops both flags to 0.
- Simultaneous traffic and wrap:
  - Preload 3 words, then run 40 cycles of wr_en=rd_en=1 with an incrementing pattern: count stays 3, output order is preserved across pointer wrap.
- FWFT mode:
  - Write 0x5A into an empty FIFO: next cycle rd_valid=1, rd_data=0x5A with no rd_en asserted.
  - Pop: empty=1, rd_data=0.
- Reset and clear mid-operation:
  - Assert rst asynchronously with 7 entries held: outputs go to their reset values immediately, without waiting for a clock edge.
  - clear together with wr_en: count stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, read-mode constants and depth helper for the sync FIFO
package fifo_pkg;

   localparam int FIFO_DATA_W = 8;
   localparam int FIFO_ADDR_W = 4;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module fifo_regfile
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = fifo_depth(ADDR_W);

   // Storage is never reset; the pointers alone decide which entries are live.
   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port: one accepted word per rising edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parametrised FIFO with FWFT option, thresholds and sticky error flags
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_W    = FIFO_DATA_W,
   parameter int ADDR_W    = FIFO_ADDR_W,
   parameter int FWFT      = FWFT_OFF,
   parameter int AFULL_TH  = fifo_depth(ADDR_W) - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH    = fifo_depth(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_V  = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_V = (ADDR_W+1)'(AEMPTY_TH);
   localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   // Refuse to build with thresholds that could never behave sensibly.
   if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("fifo_sync_param: AFULL_TH must lie in 1..DEPTH");
   end
   if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("fifo_sync_param: AEMPTY_TH must lie in 0..DEPTH-1");
   end
   if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_fwft
      $error("fifo_sync_param: FWFT must be 0 or 1");
   end

   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] mem_rdata;

   // Status comes only from registered pointers; the extra MSB separates full from empty.
   always_comb begin
      count        = wr_ptr_q - rd_ptr_q;
      full         = (count == DEPTH_V);
      empty        = (count == '0);
      almost_full  = (count >= AFULL_V);
      almost_empty = (count <= AEMPTY_V);
   end

   // Acceptance, pointer advance and sticky flags; clear overrides any request.
   always_comb begin
      wr_acc      = wr_en & ~full & ~clear;
      rd_acc      = rd_en & ~empty & ~clear;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q | (wr_en & full);
      underflow_d = underflow_q | (rd_en & empty);
      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // Pointer and flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   fifo_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (mem_rdata)
   );

   if (FWFT == FWFT_ON) begin : g_fwft
      // Head word is presented as soon as it exists; rd_en only pops it.
      assign rd_valid = ~empty;
      assign rd_data  = empty ? '0 : mem_rdata;
   end else begin : g_std
      logic [DATA_W-1:0] rd_data_q, rd_data_d;
      logic              rd_valid_q, rd_valid_d;

      // Registered read: load on an accepted read, otherwise hold the last word.
      always_comb begin
         rd_data_d  = rd_data_q;
         rd_valid_d = rd_acc;
         if (rd_acc) rd_data_d = mem_rdata;
      end

      // Output register; only rst zeroes the data, clear merely drops valid.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign rd_valid = rd_valid_q;
      assign rd_data  = rd_data_q;
   end

endmodule
